icsp_program_loader: RTL and testbench
======================================

Name: icsp_program_loader

Overview:
- Serial in-circuit programming port that writes and reads back the 14-bit program memory that the PC/instruction-fetch path reads during execution.
- Decodes a 6-bit command / 16-bit data serial protocol in the master_clk domain.
- Drives the program memory's write port and supplies read-back data.
- Holds the core (PC and fetch) in reset while programming mode is active.

Parameters:
- ADDR_W, 12, program address width; matches the PC width.
- PROG_WAIT, 16, master_clk cycles the block stays busy after a write pulse.

Ports:
- master_clk  input  1  system clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- prog_mode  input  1  programming-mode request (MCLR/VPP equivalent); level.
- icsp_clk  input  1  serial clock from the programmer; asynchronous.
- icsp_data_in  input  1  serial data from the programmer; asynchronous.
- icsp_data_out  output  1  serial read-back data.
- icsp_data_oe  output  1  high while the block drives read-back data.
- prog_addr  output  ADDR_W  program memory address.
- prog_wdata  output  14  program memory write data.
- prog_we  output  1  single-cycle write strobe.
- prog_rdata  input  14  program memory read data at prog_addr; combinational.
- cpu_hold  output  1  holds the core in reset; equals the synchronized prog_mode.
- busy  output  1  high during the write wait.

Behaviour:
- Reset: all outputs 0; prog_addr 0; state IDLE.
- Synchronization:
  - prog_mode, icsp_clk and icsp_data_in each pass through a 2-flop synchronizer.
  - Rising and falling edges of icsp_clk are detected on the synchronized signal, one master_clk cycle after the second flop.
- Serial format:
  - LSB first; the programmer samples and the block shifts on the icsp_clk falling edge.
  - Command: 6 bits.
  - Data frame: 16 bits = start bit 0, 14 data bits LSB first, stop bit 0.
- States:
  - IDLE:
    - Entered whenever synchronized prog_mode is 0.
    - prog_addr is forced to 0 and all strobes are 0.
    - A prog_mode rise moves to CMD.
  - CMD:
    - Shifts 6 bits. On the 6th falling edge, decodes:
    - 0x02 LOAD_DATA -> LOAD.
    - 0x04 READ_DATA -> READ.
    - 0x06 INC_ADDR -> prog_addr increments by 1, modulo 2^ADDR_W (max wraps to 0); stays in CMD.
    - 0x08 BEGIN_PROG -> PROGRAM.
    - Any other code is ignored; stays in CMD.
  - LOAD:
    - Shifts 16 bits; bits [14:1] latch into prog_wdata on the 16th falling edge.
    - Start and stop bit values are ignored.
    - Memory is not written.
    - Returns to CMD.
  - READ:
    - Captures prog_rdata on entry.
    - icsp_data_oe = 1 for the whole frame.
    - icsp_data_out presents the frame bit on each icsp_clk rising edge: bit0 = 0, then data LSB first, then stop 0.
    - After the 16th falling edge: oe = 0, return to CMD.
  - PROGRAM:
    - prog_we is high for exactly 1 cycle, the cycle after entry, using the current prog_addr and prog_wdata.
    - busy = 1 for PROG_WAIT cycles starting on the we cycle.
    - icsp_clk edges during busy are discarded.
    - When busy ends: busy = 0, return to CMD.
- Bit count: each shift state uses a 5-bit counter that clears on state entry.
- prog_mode deassertion mid-operation: within 3 cycles of the pin change:
  - abort to IDLE;
  - any partial command or data is discarded;
  - busy, oe and we clear;
  - prog_addr returns to 0.
- prog_wdata keeps its value across commands and is cleared only by reset.
- Simultaneous events: a prog_mode drop outranks any pending icsp_clk edge.

Test Plan:
- Reset and mode entry: reset_n low -> all outputs 0. Raise prog_mode -> cpu_hold = 1 within 3 cycles; prog_addr = 0.
- Load and program: send LOAD 0x02 with data 0x3FA5, then BEGIN_PROG 0x08 -> exactly one prog_we pulse with prog_addr = 0 and prog_wdata = 0x3FA5; busy high for 16 cycles.
- Increment and wrap: send INC_ADDR 3 times -> prog_addr = 3. With ADDR_W = 4, 16 increments from 0 -> prog_addr = 0.
- Read-back: model memory returns 0x1234 at address 3; send READ 0x04 -> icsp_data_out serial frame is 0, 0x1234 LSB first, 0; icsp_data_oe high for exactly 16 bits.
- Busy and illegal command: clock 6 bits during busy -> ignored, no state change. Send 0x3F -> no prog_we, no address change, and the next command decodes normally.
- Abort: drop prog_mode after 8 bits of a LOAD frame -> IDLE, prog_addr = 0, no prog_we, cpu_hold = 0. Re-entering programming mode and sending a full LOAD + BEGIN_PROG writes correctly.

Source files
------------

// File: rtl/icsp_program_loader.sv
// icsp_program_loader: serial ICSP command decoder driving program-memory writes and read-back.
// Async programmer inputs are synchronized into master_clk; the core is held while prog_mode is set.
module icsp_program_loader #(
  parameter int ADDR_W    = 12,
  parameter int PROG_WAIT = 16
) (
  input  logic              master_clk,
  input  logic              reset_n,
  input  logic              prog_mode,
  input  logic              icsp_clk,
  input  logic              icsp_data_in,
  output logic              icsp_data_out,
  output logic              icsp_data_oe,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [13:0]       prog_wdata,
  output logic              prog_we,
  input  logic [13:0]       prog_rdata,
  output logic              cpu_hold,
  output logic              busy
);
  localparam int WT_W = $clog2(PROG_WAIT + 1);
  typedef enum logic [2:0] {IDLE, CMD, LOAD, READ, PROGRAM} state_t;
  state_t            st_q, st_d;
  logic [1:0]        pm_q, ck_q, di_q;
  logic              ck_p_q;
  logic [4:0]        cnt_q, cnt_d;
  logic [15:0]       sh_q, sh_d, sh_n, frame;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [13:0]       wd_q, wd_d, rd_q, rd_d;
  logic [WT_W-1:0]   wt_q, wt_d;
  logic              dout_q, dout_d, pm, rise, fall;
  assign pm    = pm_q[1];
  assign rise  = ck_q[1] & ~ck_p_q;
  assign fall  = ~ck_q[1] & ck_p_q;
  assign sh_n  = {di_q[1], sh_q[15:1]};
  assign frame = {1'b0, rd_q, 1'b0};
  assign icsp_data_out = dout_q;
  assign icsp_data_oe  = st_q == READ;
  assign prog_addr     = addr_q;
  assign prog_wdata    = wd_q;
  assign prog_we       = st_q == PROGRAM && wt_q == '0;
  assign busy          = st_q == PROGRAM;
  assign cpu_hold      = pm;
  always_ff @(posedge master_clk or negedge reset_n)
    if (!reset_n) begin
      pm_q   <= '0;
      ck_q   <= '0;
      di_q   <= '0;
      ck_p_q <= 1'b0;
      st_q   <= IDLE;
      cnt_q  <= '0;
      sh_q   <= '0;
      addr_q <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
      wt_q   <= '0;
      dout_q <= 1'b0;
    end else begin
      pm_q   <= {pm_q[0], prog_mode};
      ck_q   <= {ck_q[0], icsp_clk};
      di_q   <= {di_q[0], icsp_data_in};
      ck_p_q <= ck_q[1];
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      addr_q <= addr_d;
      wd_q   <= wd_d;
      rd_q   <= rd_d;
      wt_q   <= wt_d;
      dout_q <= dout_d;
    end
  // A dropped prog_mode is checked first so it outranks any same-cycle icsp_clk edge.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    addr_d = addr_q;
    wd_d   = wd_q;
    rd_d   = rd_q;
    wt_d   = '0;
    dout_d = 1'b0;
    if (!pm) begin
      st_d   = IDLE;
      cnt_d  = '0;
      addr_d = '0;
    end else
      case (st_q)
        IDLE: st_d = CMD;
        CMD: if (fall) begin
          sh_d  = sh_n;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd5) begin
            cnt_d = '0;
            case (sh_n[15:10])
              6'h02: st_d = LOAD;
              6'h04: begin
                st_d = READ;
                rd_d = prog_rdata;
              end
              6'h06: addr_d = addr_q + 1'b1;
              6'h08: st_d = PROGRAM;
              default: ;
            endcase
          end
        end
        LOAD: if (fall) begin
          sh_d  = sh_n;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            wd_d  = sh_n[14:1];
            cnt_d = '0;
            st_d  = CMD;
          end
        end
        READ: begin
          dout_d = rise ? frame[cnt_q[3:0]] : dout_q;
          if (fall) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
              cnt_d = '0;
              st_d  = CMD;
            end
          end
        end
        PROGRAM: begin
          wt_d = wt_q + 1'b1;
          if (wt_q == WT_W'(PROG_WAIT - 1)) begin
            wt_d = '0;
            st_d = CMD;
          end
        end
        default: st_d = IDLE;
      endcase
  end
endmodule

// File: tb/tb_icsp_program_loader.sv
// tb_icsp_program_loader: directed + randomized ICSP sessions checked against a command-level model.
module tb_icsp_program_loader;
  logic clk = 0, rst_n = 0, pm = 0, ick = 0, idi = 0;
  logic dout, doe, we, hold, bsy, dout4, doe4, we4, hold4, bsy4;
  logic [11:0] addr;
  logic [3:0]  addr4;
  logic [13:0] wd, wd4, rdata, rdata4;
  logic [13:0] mem [4096];
  logic [13:0] mem4 [16];
  logic [13:0] exp_mem [4096];
  logic [13:0] exp_wd = 0;
  logic [11:0] we_addr = 0;
  logic [13:0] we_data = 0;
  int exp_addr = 0, errors = 0, checks = 0, we_n = 0, busy_n = 0;

  always #5 clk = ~clk;

  icsp_program_loader dut (
    .master_clk(clk), .reset_n(rst_n), .prog_mode(pm), .icsp_clk(ick), .icsp_data_in(idi),
    .icsp_data_out(dout), .icsp_data_oe(doe), .prog_addr(addr), .prog_wdata(wd), .prog_we(we),
    .prog_rdata(rdata), .cpu_hold(hold), .busy(bsy)
  );
  icsp_program_loader #(.ADDR_W(4)) dut4 (
    .master_clk(clk), .reset_n(rst_n), .prog_mode(pm), .icsp_clk(ick), .icsp_data_in(idi),
    .icsp_data_out(dout4), .icsp_data_oe(doe4), .prog_addr(addr4), .prog_wdata(wd4), .prog_we(we4),
    .prog_rdata(rdata4), .cpu_hold(hold4), .busy(bsy4)
  );

  function automatic logic [13:0] init_word(input int i);
    return (i == 3) ? 14'h1234 : 14'(i * 977 + 5);
  endfunction

  assign rdata  = mem[addr];
  assign rdata4 = mem4[addr4];

  always @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
      for (int i = 0; i < 16; i++) mem4[i] <= init_word(i);
    end else begin
      if (we) mem[addr] <= wd;
      if (we4) mem4[addr4] <= wd4;
    end

  always @(negedge clk) begin
    if (we) begin
      we_n    <= we_n + 1;
      we_addr <= addr;
      we_data <= wd;
    end
    if (bsy) busy_n <= busy_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic send_bit(input logic b, input int hp, output logic so, output logic oe);
    idi = b;
    ick = 1;
    repeat (hp) @(negedge clk);
    so  = dout;
    oe  = doe;
    ick = 0;
    repeat (hp) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [5:0] c, input int hp);
    logic so, oe;
    for (int i = 0; i < 6; i++) send_bit(c[i], hp, so, oe);
  endtask

  task automatic cmd_inc();
    send_cmd(6'h06, 4);
    exp_addr++;
  endtask

  task automatic cmd_load(input logic [13:0] d);
    logic [15:0] f;
    logic so, oe;
    send_cmd(6'h02, 4);
    f = {1'b0, d, 1'b0};
    for (int i = 0; i < 16; i++) send_bit(f[i], 4, so, oe);
    exp_wd = d;
    chk("load_wdata", 32'(wd), 32'(exp_wd));
  endtask

  task automatic cmd_prog(input bit burst);
    int w0, b0;
    w0 = we_n;
    b0 = busy_n;
    send_cmd(6'h08, 4);
    if (burst) send_cmd(6'h06, 1);
    repeat (24) @(negedge clk);
    exp_mem[exp_addr % 4096] = exp_wd;
    chk("prog_we_pulses", 32'(we_n - w0), 32'd1);
    chk("prog_we_addr", 32'(we_addr), 32'(exp_addr % 4096));
    chk("prog_we_data", 32'(we_data), 32'(exp_wd));
    chk("prog_busy_cycles", 32'(busy_n - b0), 32'd16);
    chk("prog_addr_after", 32'(addr), 32'(exp_addr % 4096));
  endtask

  task automatic cmd_read();
    logic [15:0] f;
    logic so, oe;
    int n;
    n = 0;
    send_cmd(6'h04, 4);
    for (int i = 0; i < 16; i++) begin
      send_bit(1'b0, 4, so, oe);
      f[i] = so;
      n += int'(oe);
    end
    chk("read_frame", 32'(f), 32'({1'b0, exp_mem[exp_addr % 4096], 1'b0}));
    chk("read_oe_bits", 32'(n), 32'd16);
    chk("read_oe_after", 32'(doe), 32'd0);
  endtask

  initial begin
    logic [13:0] d;
    logic so, oe;
    int w0;
    for (int i = 0; i < 4096; i++) exp_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    chk("rst_out", {26'd0, dout, doe, we, hold, bsy, 1'b0}, 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", 32'(wd), 32'd0);
    rst_n = 1;
    @(negedge clk);
    pm = 1;
    repeat (3) @(negedge clk);
    chk("entry_hold", 32'(hold), 32'd1);
    chk("entry_addr", 32'(addr), 32'd0);
    repeat (3) @(negedge clk);
    cmd_load(14'h3FA5);
    cmd_prog(1);
    repeat (3) cmd_inc();
    chk("inc3_addr", 32'(addr), 32'd3);
    chk("inc3_addr4", 32'(addr4), 32'd3);
    cmd_read();
    w0 = we_n;
    send_cmd(6'h3F, 4);
    repeat (24) @(negedge clk);
    chk("illegal_no_we", 32'(we_n), 32'(w0));
    chk("illegal_addr", 32'(addr), 32'(exp_addr % 4096));
    cmd_inc();
    chk("post_illegal_inc", 32'(addr), 32'(exp_addr % 4096));
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 2)) cmd_inc();
      send_cmd(6'(2 * $urandom_range(5, 31) + 1), 4);
      d = 14'($urandom);
      cmd_load(d);
      cmd_prog(0);
      cmd_read();
      chk("rnd_addr4", 32'(addr4), 32'(exp_addr % 16));
    end
    w0 = we_n;
    send_cmd(6'h02, 4);
    for (int i = 0; i < 8; i++) send_bit(1'($urandom), 4, so, oe);
    pm = 0;
    repeat (3) @(negedge clk);
    exp_addr = 0;
    chk("abort_hold", 32'(hold), 32'd0);
    chk("abort_addr", 32'(addr), 32'd0);
    chk("abort_busy_oe", {30'd0, bsy, doe}, 32'd0);
    chk("abort_no_we", 32'(we_n), 32'(w0));
    chk("abort_wdata_kept", 32'(wd), 32'(exp_wd));
    repeat (4) @(negedge clk);
    pm = 1;
    repeat (6) @(negedge clk);
    cmd_load(14'h2C3B);
    cmd_prog(0);
    cmd_read();
    repeat (16) cmd_inc();
    chk("wrap_addr4", 32'(addr4), 32'd0);
    chk("nowrap_addr12", 32'(addr), 32'd16);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
